// File: rtl/ysyx_22040237_div_ctrl.sv
// ysyx_22040237_div_ctrl
//   Multi-cycle integer divider for RV64 div/divu/rem/remu and their word
//   forms. Restoring shift-subtract on operand magnitudes, one quotient bit
//   per cycle. Divide-by-zero and signed overflow finish without iterating.
//
// Ports
//   clk, rst      : clock, asynchronous active-high reset
//   req_valid_i   : request valid; accepted when req_ready_o is high
//   req_ready_o   : controller idle, can accept a request
//   op1_i, op2_i  : dividend, divisor (sampled only at accept)
//   div_op_i      : 00 div, 01 divu, 10 rem, 11 remu
//   wop_i         : 32-bit word operation
//   flush_i       : abort whatever is in flight; wins over everything
//   res_valid_o   : result valid (held until res_ready_i)
//   res_ready_i   : consumer takes the result
//   res_o         : quotient or remainder, zero when res_valid_o is low
//   busy_o        : high whenever not idle (pipeline stall)
module ysyx_22040237_div_ctrl #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [1:0]      div_op_i,
  input  logic            wop_i,
  input  logic            flush_i,
  output logic            res_valid_o,
  input  logic            res_ready_i,
  output logic [XLEN-1:0] res_o,
  output logic            busy_o
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic [5:0]      cnt;
  logic [XLEN-1:0] rem_q, quo_q, dvs_q;
  logic            is_rem_q, is_word_q, neg_q_q, neg_r_q;

  // Word results are always the low 32 bits sign-extended.
  function automatic logic [XLEN-1:0] word_fix(input logic w, input logic [XLEN-1:0] v);
    return w ? {{32{v[31]}}, v[31:0]} : v;
  endfunction

  function automatic logic [XLEN-1:0] neg_if(input logic c, input logic [XLEN-1:0] v);
    return c ? (~v + 1'b1) : v;
  endfunction

  assign req_ready_o = (state == IDLE);
  assign busy_o      = (state != IDLE);

  // Operand preparation at the operating width (combinational, accept cycle).
  logic                   is_signed, a_neg, b_neg, div_zero, ovf, accept;
  logic signed [XLEN-1:0] a_ext, b_ext;
  logic [XLEN-1:0]        a_mag, b_mag, spec_res;

  always_comb begin
    is_signed = ~div_op_i[0];
    if (wop_i) begin
      a_ext = is_signed ? {{32{op1_i[31]}}, op1_i[31:0]} : {32'b0, op1_i[31:0]};
      b_ext = is_signed ? {{32{op2_i[31]}}, op2_i[31:0]} : {32'b0, op2_i[31:0]};
    end else begin
      a_ext = op1_i;
      b_ext = op2_i;
    end
    a_neg    = is_signed & a_ext[XLEN-1];
    b_neg    = is_signed & b_ext[XLEN-1];
    a_mag    = neg_if(a_neg, $unsigned(a_ext));
    b_mag    = neg_if(b_neg, $unsigned(b_ext));
    div_zero = (b_ext == '0);
    // Sign-extended word operands make the 64-bit compare cover both widths.
    ovf      = is_signed && (b_ext == '1) &&
               (wop_i ? (a_ext == 64'hFFFF_FFFF_8000_0000)
                      : (a_ext == 64'h8000_0000_0000_0000));
    if (div_zero)
      spec_res = div_op_i[1] ? $unsigned(a_ext) : '1;
    else
      spec_res = div_op_i[1] ? '0 : $unsigned(a_ext);
    spec_res = word_fix(wop_i, spec_res);
    accept   = req_valid_i && req_ready_o && !flush_i;
  end

  // One restoring step; also used to form the final result on the last step.
  logic [XLEN:0]   r_sh, diff;
  logic            q_bit;
  logic [XLEN-1:0] quo_next, rem_next, quo_mag, fin_res;

  always_comb begin
    r_sh     = {rem_q, quo_q[XLEN-1]};
    diff     = r_sh - {1'b0, dvs_q};
    q_bit    = ~diff[XLEN];
    quo_next = {quo_q[XLEN-2:0], q_bit};
    rem_next = q_bit ? diff[XLEN-1:0] : r_sh[XLEN-1:0];
    quo_mag  = is_word_q ? {32'b0, quo_next[31:0]} : quo_next;
    fin_res  = word_fix(is_word_q, is_rem_q ? neg_if(neg_r_q, rem_next)
                                            : neg_if(neg_q_q, quo_mag));
  end

  // ---- datapath registers (no reset) ----
  always_ff @(posedge clk) begin
    if (accept) begin
      rem_q     <= '0;
      // Word dividends are left-aligned so the MSB is always shifted first.
      quo_q     <= wop_i ? {a_mag[31:0], 32'b0} : a_mag;
      dvs_q     <= b_mag;
      is_rem_q  <= div_op_i[1];
      is_word_q <= wop_i;
      neg_q_q   <= a_neg ^ b_neg;
      neg_r_q   <= a_neg;
    end else if (state == CALC) begin
      rem_q <= rem_next;
      quo_q <= quo_next;
    end
  end

  // ---- control FSM and registered result ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      res_valid_o <= 1'b0;
      res_o       <= '0;
    end else if (flush_i) begin
      state       <= IDLE;
      cnt         <= '0;
      res_valid_o <= 1'b0;
      res_o       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            if (div_zero || ovf) begin
              state       <= DONE;
              res_valid_o <= 1'b1;
              res_o       <= spec_res;
            end else begin
              state <= CALC;
              cnt   <= wop_i ? 6'd31 : 6'd63;
            end
          end
        end
        CALC: begin
          cnt <= cnt - 6'd1;
          if (cnt == 6'd0) begin
            state       <= DONE;
            res_valid_o <= 1'b1;
            res_o       <= fin_res;
          end
        end
        DONE: begin
          if (res_ready_i) begin
            state       <= IDLE;
            res_valid_o <= 1'b0;
            res_o       <= '0;
          end
        end
        default: begin
          state       <= IDLE;
          res_valid_o <= 1'b0;
          res_o       <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22040237_div_ctrl.sv
// Directed bench for ysyx_22040237_div_ctrl.
module tb_ysyx_22040237_div_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [63:0] op1, op2;
  logic [1:0]  div_op;
  logic        wop, flush;
  logic        res_valid, res_ready;
  logic [63:0] res;
  logic        busy;

  int tests = 0;
  int fails = 0;

  ysyx_22040237_div_ctrl #(.XLEN(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .op1_i(op1), .op2_i(op2), .div_op_i(div_op), .wop_i(wop),
    .flush_i(flush),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_o(res),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request at a negedge, measure latency, optionally hold off
  // res_ready for 'hold' cycles, then complete the handshake.
  task automatic do_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                       input logic [1:0] op, input logic w, input logic [63:0] exp,
                       input int exp_lat, input int hold);
    int lat;
    lat = 0;
    chk({tag, "/ready"}, 64'(req_ready), 64'd1);
    op1 = a; op2 = b; div_op = op; wop = w; req_valid = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      op1 = ~a; op2 = ~b; div_op = ~op; wop = ~w;
      if (res_valid) begin
        lat = k;
        break;
      end
    end
    chk({tag, "/lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "/res"}, res, exp);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, "/hold_vld"}, 64'(res_valid), 64'd1);
      chk({tag, "/hold_res"}, res, exp);
    end
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    chk({tag, "/after_vld"}, 64'(res_valid), 64'd0);
    chk({tag, "/after_res"}, res, 64'd0);
  endtask

  initial begin
    int seen;
    rst = 1'b1; req_valid = 1'b0; op1 = '0; op2 = '0; div_op = '0;
    wop = 1'b0; flush = 1'b0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst/vld",   64'(res_valid), 64'd0);
    chk("rst/res",   res,            64'd0);
    chk("rst/busy",  64'(busy),      64'd0);
    chk("rst/ready", 64'(req_ready), 64'd1);
    rst = 1'b0;
    @(negedge clk);

    do_op("divu",  64'd100, 64'd7, 2'b01, 1'b0, 64'd14, 65, 0);
    do_op("remu",  64'd100, 64'd7, 2'b11, 1'b0, 64'd2,  65, 0);
    do_op("div",   -64'sd7, 64'd2, 2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 65, 0);
    do_op("rem",   -64'sd7, 64'd2, 2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
    do_op("divu0", 64'd5, 64'd0, 2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    do_op("remu0", 64'd5, 64'd0, 2'b11, 1'b0, 64'd5, 1, 0);
    do_op("divw0", 64'd5, 64'd0, 2'b00, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    do_op("divov", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 1'b0,
          64'h8000_0000_0000_0000, 1, 0);
    do_op("remov", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 1'b0,
          64'd0, 1, 0);
    do_op("divwov", 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 2'b00, 1'b1,
          64'hFFFF_FFFF_8000_0000, 1, 0);
    do_op("divuw", 64'hFFFF_FFFF_FFFF_FFF0, 64'h10, 2'b01, 1'b1,
          64'h0000_0000_0FFF_FFFF, 33, 0);
    do_op("remuw", 64'hFFFF_FFFF_0000_0007, 64'h8000_0000, 2'b11, 1'b1, 64'd7, 33, 0);
    do_op("remw",  64'h0000_0000_FFFF_FFF9, 64'd2, 2'b10, 1'b1,
          64'hFFFF_FFFF_FFFF_FFFF, 33, 0);

    // Flush in cycle 10 of CALC.
    seen = 0;
    op1 = 64'd1000; op2 = 64'd3; div_op = 2'b01; wop = 1'b0; req_valid = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (res_valid) seen = 1;
    end
    @(negedge clk);
    chk("flush/busy_before", 64'(busy), 64'd1);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    chk("flush/busy",  64'(busy),      64'd0);
    chk("flush/ready", 64'(req_ready), 64'd1);
    for (int k = 0; k < 70; k++) begin
      if (res_valid) seen = 1;
      @(negedge clk);
    end
    chk("flush/no_vld", 64'(seen), 64'd0);

    // Request after flush, with 5 cycles of backpressure.
    do_op("postflush", 64'd1000, 64'd3, 2'b01, 1'b0, 64'd333, 65, 5);

    // Reset mid-CALC.
    seen = 0;
    op1 = 64'd50; op2 = 64'd5; div_op = 2'b01; wop = 1'b0; req_valid = 1'b1;
    @(posedge clk);
    repeat (5) @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst/busy", 64'(busy),      64'd0);
    chk("midrst/vld",  64'(res_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (res_valid) seen = 1;
    end
    chk("midrst/no_vld", 64'(seen), 64'd0);
    do_op("postrst", 64'd50, 64'd5, 2'b01, 1'b0, 64'd10, 65, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
